// File: rtl/sample_sched_pkg.sv
// Shared types and widths for the sample frame scheduler.
// Frames pair one frequency word with one amplitude word.
package sample_sched_pkg;

    localparam int FREQ_W = 14;
    localparam int AMP_W  = 8;

    typedef enum logic [0:0] {
        WORD_FREQ = 1'b0,
        WORD_AMP  = 1'b1
    } word_type_e;

    typedef enum logic [0:0] {
        WAIT_FREQ = 1'b0,
        WAIT_AMP  = 1'b1
    } asm_state_e;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [AMP_W-1:0]  amp;
    } frame_t;

endpackage

// File: rtl/sample_sched_if.sv
// Word input, playback tick and sample output bundle.
// LEVEL_W must equal $clog2(FIFO_DEPTH)+1 of the scheduler.
interface sample_sched_if
    import sample_sched_pkg::*;
#(
    parameter int LEVEL_W = 3
);

    logic               word_valid;
    logic [15:0]        word_data;
    logic               sample_tick;
    logic [FREQ_W-1:0]  outputFrequencySample;
    logic [AMP_W-1:0]   outputAmplitudeSample;
    logic               sample_strobe;
    logic [LEVEL_W-1:0] fifo_level;
    logic               frame_error;
    logic               link_active;

    modport master (
        output word_valid,
        output word_data,
        output sample_tick,
        input  outputFrequencySample,
        input  outputAmplitudeSample,
        input  sample_strobe,
        input  fifo_level,
        input  frame_error,
        input  link_active
    );

    modport slave (
        input  word_valid,
        input  word_data,
        input  sample_tick,
        output outputFrequencySample,
        output outputAmplitudeSample,
        output sample_strobe,
        output fifo_level,
        output frame_error,
        output link_active
    );

endinterface

// File: rtl/sample_frame_fifo.sv
// Frame FIFO with registered read port and level counter.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module sample_frame_fifo
    import sample_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  frame_t                 wr_frame,
    input  logic                   pop,
    output frame_t                 rd_frame,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    frame_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    frame_t        rd_q, rd_d;
    logic          do_push, do_pop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    assign rd_frame = rd_q;
    assign level    = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rd_d     = rd_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            rd_d     = mem_q[rd_ptr_q];
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage needs no reset; validity is tracked by the level.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rd_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rd_q     <= rd_d;
        end
    end

endmodule

// File: rtl/sample_frame_scheduler.sv
// Assembles frequency/amplitude word pairs into frames and plays them
// out one per sample tick, muting after a run of underruns.
module sample_frame_scheduler
    import sample_sched_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int MUTE_TICKS     = 64
) (
    input logic           CLK_50Mhz,
    input logic           reset,
    sample_sched_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int UW = $clog2(MUTE_TICKS + 1);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    asm_state_e        state_q, state_d;
    logic [FREQ_W-1:0] pend_q, pend_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [UW-1:0]     urun_q, urun_d;
    logic              err_q, err_d;
    logic              strobe_q, strobe_d;

    word_type_e        wtype;
    logic              push, proto_err;
    logic              pop_ok;
    frame_t            wr_frame, rd_frame;
    logic              fifo_full, fifo_empty, overflow;
    logic [LW-1:0]     level;
    logic              muted;
    logic              unused_bits;

    assign wtype       = word_type_e'(bus.word_data[15]);
    assign unused_bits = ^{bus.word_data[14], fifo_full};

    assign wr_frame.freq = pend_q;
    assign wr_frame.amp  = bus.word_data[AMP_W-1:0];

    sample_frame_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK_50Mhz),
        .rst      (reset),
        .push     (push),
        .wr_frame (wr_frame),
        .pop      (bus.sample_tick),
        .rd_frame (rd_frame),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (overflow),
        .level    (level)
    );

    // Pop decision uses the pre-cycle level, so a same-cycle push
    // into an empty FIFO cannot satisfy the tick.
    assign pop_ok = bus.sample_tick && !fifo_empty;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        tmo_d     = tmo_q;
        push      = 1'b0;
        proto_err = 1'b0;
        unique case (state_q)
            WAIT_FREQ: begin
                if (bus.word_valid) begin
                    if (wtype == WORD_FREQ) begin
                        pend_d  = bus.word_data[FREQ_W-1:0];
                        tmo_d   = '0;
                        state_d = WAIT_AMP;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
            end
            WAIT_AMP: begin
                if (bus.word_valid) begin
                    tmo_d = '0;
                    if (wtype == WORD_FREQ) begin
                        pend_d    = bus.word_data[FREQ_W-1:0];
                        proto_err = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = WAIT_FREQ;
                    end
                end else if (tmo_q + TW'(1) == TW'(TIMEOUT_CYCLES)) begin
                    tmo_d     = '0;
                    proto_err = 1'b1;
                    state_d   = WAIT_FREQ;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = WAIT_FREQ;
        endcase
    end

    always_comb begin
        urun_d   = urun_q;
        strobe_d = pop_ok;
        err_d    = proto_err || overflow;
        unique case (1'b1)
            pop_ok: urun_d = '0;
            bus.sample_tick && fifo_empty && (urun_q < UW'(MUTE_TICKS)):
                urun_d = urun_q + UW'(1);
            default: urun_d = urun_q;
        endcase
    end

    always_ff @(posedge CLK_50Mhz) begin
        if (reset) begin
            state_q  <= WAIT_FREQ;
            pend_q   <= '0;
            tmo_q    <= '0;
            urun_q   <= UW'(MUTE_TICKS);
            err_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            tmo_q    <= tmo_d;
            urun_q   <= urun_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
        end
    end

    assign muted = (urun_q >= UW'(MUTE_TICKS));

    assign bus.outputFrequencySample = rd_frame.freq;
    assign bus.outputAmplitudeSample = muted ? '0 : rd_frame.amp;
    assign bus.sample_strobe         = strobe_q;
    assign bus.fifo_level            = level;
    assign bus.frame_error           = err_q;
    assign bus.link_active           = !muted;

endmodule

// File: tb/tb_sample_frame_scheduler.sv
// Directed bench for the sample frame scheduler.
// Each task drives one scenario and checks against hand-computed values.
module tb_sample_frame_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #10 clk = ~clk;

    sample_sched_if #(.LEVEL_W(3)) bus ();

    sample_frame_scheduler #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (2048),
        .MUTE_TICKS     (64)
    ) dut (
        .CLK_50Mhz (clk),
        .reset     (rst),
        .bus       (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input logic tk);
        bus.word_valid  = 1'b1;
        bus.word_data   = w;
        bus.sample_tick = tk;
        cyc();
        bus.word_valid  = 1'b0;
        bus.sample_tick = 1'b0;
    endtask

    task automatic tick();
        bus.sample_tick = 1'b1;
        cyc();
        bus.sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        bus.word_valid  = 1'b0;
        bus.word_data   = '0;
        bus.sample_tick = 1'b0;
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        tests++;
        if (bus.fifo_level !== 3'd0) begin
            fails++; $display("FAIL rst_level got %0d want 0", bus.fifo_level);
        end
        tests++;
        if (bus.outputFrequencySample !== 14'h0 || bus.outputAmplitudeSample !== 8'h0) begin
            fails++;
            $display("FAIL rst_out got %h/%h want 0/0",
                     bus.outputFrequencySample, bus.outputAmplitudeSample);
        end
        tests++;
        if (bus.link_active !== 1'b0) begin
            fails++; $display("FAIL rst_link got %b want 0", bus.link_active);
        end
        tests++;
        if (bus.sample_strobe !== 1'b0 || bus.frame_error !== 1'b0) begin
            fails++;
            $display("FAIL rst_pulses got strobe=%b err=%b want 0/0",
                     bus.sample_strobe, bus.frame_error);
        end
    endtask

    task automatic test_basic();
        send(16'h0123, 1'b0);
        send(16'h8040, 1'b0);
        tests++;
        if (bus.fifo_level !== 3'd1 || bus.frame_error !== 1'b0) begin
            fails++;
            $display("FAIL basic_push got lvl=%0d err=%b want 1/0",
                     bus.fifo_level, bus.frame_error);
        end
        tick();
        tests++;
        if (bus.outputFrequencySample !== 14'h0123 || bus.outputAmplitudeSample !== 8'h40
            || bus.sample_strobe !== 1'b1 || bus.fifo_level !== 3'd0) begin
            fails++;
            $display("FAIL basic_pop got %h/%h s=%b l=%0d want 0123/40 s=1 l=0",
                     bus.outputFrequencySample, bus.outputAmplitudeSample,
                     bus.sample_strobe, bus.fifo_level);
        end
        tests++;
        if (bus.link_active !== 1'b1) begin
            fails++; $display("FAIL basic_link got %b want 1", bus.link_active);
        end
        cyc();
        tests++;
        if (bus.sample_strobe !== 1'b0) begin
            fails++; $display("FAIL basic_strobe_len got %b want 0", bus.sample_strobe);
        end
    endtask

    task automatic test_stray_amp();
        send(16'h8010, 1'b0);
        tests++;
        if (bus.frame_error !== 1'b1 || bus.fifo_level !== 3'd0) begin
            fails++;
            $display("FAIL stray_amp got err=%b lvl=%0d want 1/0",
                     bus.frame_error, bus.fifo_level);
        end
        cyc();
        tests++;
        if (bus.frame_error !== 1'b0) begin
            fails++; $display("FAIL stray_err_len got %b want 0", bus.frame_error);
        end
        send(16'h0200, 1'b0);
        send(16'h8020, 1'b0);
        tick();
        tests++;
        if (bus.outputFrequencySample !== 14'h0200 || bus.outputAmplitudeSample !== 8'h20) begin
            fails++;
            $display("FAIL stray_next got %h/%h want 0200/20",
                     bus.outputFrequencySample, bus.outputAmplitudeSample);
        end
    endtask

    task automatic test_double_freq();
        send(16'h0111, 1'b0);
        send(16'h0222, 1'b0);
        tests++;
        if (bus.frame_error !== 1'b1) begin
            fails++; $display("FAIL dbl_freq_err got %b want 1", bus.frame_error);
        end
        send(16'h8044, 1'b0);
        tick();
        tests++;
        if (bus.outputFrequencySample !== 14'h0222 || bus.outputAmplitudeSample !== 8'h44) begin
            fails++;
            $display("FAIL dbl_freq_out got %h/%h want 0222/44",
                     bus.outputFrequencySample, bus.outputAmplitudeSample);
        end
    endtask

    task automatic test_timeout();
        int first = -1;
        int pulses = 0;
        send(16'h0100, 1'b0);
        for (int i = 1; i <= 2100; i++) begin
            cyc();
            if (bus.frame_error === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        tests++;
        if (first !== 2048 || pulses !== 1) begin
            fails++;
            $display("FAIL timeout got at=%0d pulses=%0d want 2048/1", first, pulses);
        end
        send(16'h8033, 1'b0);
        tests++;
        if (bus.frame_error !== 1'b1 || bus.fifo_level !== 3'd0) begin
            fails++;
            $display("FAIL timeout_amp got err=%b lvl=%0d want 1/0",
                     bus.frame_error, bus.fifo_level);
        end
    endtask

    task automatic test_overflow();
        logic [13:0] exp_f [4];
        for (int i = 1; i <= 4; i++) begin
            send(16'h0010 + 16'(i), 1'b0);
            send(16'h8020 + 16'(i), 1'b0);
        end
        tests++;
        if (bus.fifo_level !== 3'd4) begin
            fails++; $display("FAIL ovf_fill got %0d want 4", bus.fifo_level);
        end
        send(16'h0015, 1'b0);
        send(16'h8025, 1'b0);
        tests++;
        if (bus.frame_error !== 1'b1 || bus.fifo_level !== 3'd4) begin
            fails++;
            $display("FAIL ovf_drop got err=%b lvl=%0d want 1/4",
                     bus.frame_error, bus.fifo_level);
        end
        send(16'h0016, 1'b0);
        send(16'h8026, 1'b1);
        tests++;
        if (bus.frame_error !== 1'b0 || bus.fifo_level !== 3'd4
            || bus.sample_strobe !== 1'b1 || bus.outputFrequencySample !== 14'h0011
            || bus.outputAmplitudeSample !== 8'h21) begin
            fails++;
            $display("FAIL full_pushpop got err=%b l=%0d s=%b %h/%h want 0/4/1 0011/21",
                     bus.frame_error, bus.fifo_level, bus.sample_strobe,
                     bus.outputFrequencySample, bus.outputAmplitudeSample);
        end
        exp_f[0] = 14'h0012;
        exp_f[1] = 14'h0013;
        exp_f[2] = 14'h0014;
        exp_f[3] = 14'h0016;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (bus.outputFrequencySample !== exp_f[i]
                || bus.outputAmplitudeSample !== 8'(exp_f[i] + 14'h0010)) begin
                fails++;
                $display("FAIL ovf_order%0d got %h/%h want %h/%h", i,
                         bus.outputFrequencySample, bus.outputAmplitudeSample,
                         exp_f[i], 8'(exp_f[i] + 14'h0010));
            end
        end
        tests++;
        if (bus.fifo_level !== 3'd0) begin
            fails++; $display("FAIL ovf_drain got %0d want 0", bus.fifo_level);
        end
    endtask

    task automatic test_reset_mid();
        send(16'h0501, 1'b0);
        send(16'h8001, 1'b0);
        send(16'h0502, 1'b0);
        send(16'h8002, 1'b0);
        send(16'h0503, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        tests++;
        if (bus.fifo_level !== 3'd0 || bus.outputFrequencySample !== 14'h0
            || bus.outputAmplitudeSample !== 8'h0 || bus.link_active !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid got l=%0d %h/%h link=%b want 0 0/0 0",
                     bus.fifo_level, bus.outputFrequencySample,
                     bus.outputAmplitudeSample, bus.link_active);
        end
        send(16'h8011, 1'b0);
        tests++;
        if (bus.frame_error !== 1'b1 || bus.fifo_level !== 3'd0) begin
            fails++;
            $display("FAIL rst_mid_amp got err=%b lvl=%0d want 1/0",
                     bus.frame_error, bus.fifo_level);
        end
    endtask

    task automatic test_empty_race();
        send(16'h0400, 1'b0);
        send(16'h8066, 1'b1);
        tests++;
        if (bus.sample_strobe !== 1'b0 || bus.fifo_level !== 3'd1
            || bus.outputFrequencySample !== 14'h0) begin
            fails++;
            $display("FAIL race got s=%b l=%0d f=%h want 0/1/0000",
                     bus.sample_strobe, bus.fifo_level, bus.outputFrequencySample);
        end
        tick();
        tests++;
        if (bus.outputFrequencySample !== 14'h0400 || bus.outputAmplitudeSample !== 8'h66
            || bus.link_active !== 1'b1) begin
            fails++;
            $display("FAIL race_pop got %h/%h link=%b want 0400/66 1",
                     bus.outputFrequencySample, bus.outputAmplitudeSample, bus.link_active);
        end
    endtask

    task automatic test_mute();
        send(16'h0300, 1'b0);
        send(16'h807F, 1'b0);
        tick();
        repeat (63) tick();
        tests++;
        if (bus.outputAmplitudeSample !== 8'h7F || bus.link_active !== 1'b1) begin
            fails++;
            $display("FAIL mute_63 got amp=%h link=%b want 7f/1",
                     bus.outputAmplitudeSample, bus.link_active);
        end
        tick();
        tests++;
        if (bus.outputAmplitudeSample !== 8'h00 || bus.link_active !== 1'b0
            || bus.outputFrequencySample !== 14'h0300 || bus.sample_strobe !== 1'b0) begin
            fails++;
            $display("FAIL mute_64 got amp=%h link=%b f=%h s=%b want 00/0/0300/0",
                     bus.outputAmplitudeSample, bus.link_active,
                     bus.outputFrequencySample, bus.sample_strobe);
        end
        send(16'h0301, 1'b0);
        send(16'h8055, 1'b0);
        tick();
        tests++;
        if (bus.outputAmplitudeSample !== 8'h55 || bus.link_active !== 1'b1
            || bus.outputFrequencySample !== 14'h0301) begin
            fails++;
            $display("FAIL unmute got amp=%h link=%b f=%h want 55/1/0301",
                     bus.outputAmplitudeSample, bus.link_active, bus.outputFrequencySample);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stray_amp();
        test_double_freq();
        test_timeout();
        test_overflow();
        test_reset_mid();
        test_empty_race();
        test_mute();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
